game_flow_controller: RTL and testbench

Top-level sequencer for the reaction game: owns the game state machine, drives the countdown timer's clear/enable controls, and converts miss events into a flow-controlled penalty request stream the timer consumes at its own tick rate. It also maintains the score, level and best score shown on the display. It sits between the button/hit-detection logic and the countdown timer.

---
 rtl/game_flow_controller.sv | 166 ++++++++++++++++
 tb/tb_game_flow_controller.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_controller.sv
// game_flow_controller
// Reaction-game sequencer: runs the IDLE/ARM/PLAY/PAUSE/OVER state machine,
// drives the countdown timer's clear/enable, turns miss events into a
// valid/ready penalty request stream, and keeps score, level and best score.
module game_flow_controller #(
    parameter int ARM_CYCLES = 150000000,
    parameter int HIT_POINTS = 10,
    parameter int LEVEL_HITS = 8,
    parameter int MAX_LEVEL  = 9,
    parameter int PEND_MAX   = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        pause,
    input  logic        hit,
    input  logic        miss,
    input  logic        timer_expired,
    input  logic        penalty_ack,
    output logic        timer_clr,
    output logic        timer_en,
    output logic        penalty_req,
    output logic [2:0]  state,
    output logic [15:0] score,
    output logic [15:0] best_score,
    output logic [3:0]  level,
    output logic        game_over
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    // Counter widths sized so the largest loaded value just fits.
    localparam int ARM_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
    localparam int HIT_W = (LEVEL_HITS > 1) ? $clog2(LEVEL_HITS) : 1;

    localparam logic [ARM_W-1:0] ARM_LOAD  = ARM_W'(ARM_CYCLES - 1);
    localparam logic [HIT_W-1:0] HIT_WRAP  = HIT_W'(LEVEL_HITS - 1);
    localparam logic [3:0]       LEVEL_TOP = 4'(MAX_LEVEL);
    localparam logic [3:0]       PEND_TOP  = 4'(PEND_MAX);
    localparam logic [16:0]      HIT_ADD   = 17'(HIT_POINTS);

    state_t           state_reg;
    state_t           state_next;
    logic             start_q_reg;
    logic [ARM_W-1:0] arm_cnt_reg;
    logic [HIT_W-1:0] hit_cnt_reg;
    logic [3:0]       pend_reg;
    logic [15:0]      score_reg;
    logic [15:0]      best_reg;
    logic [3:0]       level_reg;
    logic             timer_clr_reg;
    logic             timer_en_reg;
    logic             game_over_reg;

    logic        start_rise;
    logic        play_evt;
    logic        miss_evt;
    logic        hit_evt;
    logic        pend_ack;
    logic        restart;
    logic        over_entry;
    logic [16:0] score_sum;

    // Event qualification: hits/misses only count in PLAY when neither expiry
    // nor pause wins the cycle, and a miss swallows a simultaneous hit.
    assign start_rise  = start & ~start_q_reg;
    assign play_evt    = (state_reg == ST_PLAY) && !timer_expired && !pause;
    assign miss_evt    = play_evt && miss;
    assign hit_evt     = play_evt && hit && !miss;
    assign penalty_req = (state_reg == ST_PLAY) && (pend_reg != 4'd0);
    assign pend_ack    = penalty_req && penalty_ack;
    assign restart     = ((state_reg == ST_IDLE) || (state_reg == ST_OVER)) && start_rise;
    assign over_entry  = (state_next == ST_OVER) && (state_reg != ST_OVER);
    assign score_sum   = {1'b0, score_reg} + HIT_ADD;

    assign state      = state_reg;
    assign score      = score_reg;
    assign best_score = best_reg;
    assign level      = level_reg;
    assign timer_clr  = timer_clr_reg;
    assign timer_en   = timer_en_reg;
    assign game_over  = game_over_reg;

    // Next-state selection; expiry outranks pause in both PLAY and PAUSE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start_rise) state_next = ST_ARM;
            ST_ARM:   if (arm_cnt_reg == '0) state_next = ST_PLAY;
            ST_PLAY: begin
                if (timer_expired)  state_next = ST_OVER;
                else if (pause)     state_next = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (timer_expired)  state_next = ST_OVER;
                else if (pause)     state_next = ST_PLAY;
            end
            ST_OVER:  if (start_rise) state_next = ST_ARM;
            default:  state_next = ST_IDLE;
        endcase
    end

    // State, registered timer controls, and score/level/penalty bookkeeping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            start_q_reg   <= 1'b1;
            arm_cnt_reg   <= '0;
            hit_cnt_reg   <= '0;
            pend_reg      <= 4'd0;
            score_reg     <= 16'd0;
            best_reg      <= 16'd0;
            level_reg     <= 4'd1;
            timer_clr_reg <= 1'b1;
            timer_en_reg  <= 1'b0;
            game_over_reg <= 1'b0;
        end else begin
            start_q_reg   <= start;
            state_reg     <= state_next;
            timer_clr_reg <= (state_next == ST_IDLE) || (state_next == ST_ARM);
            timer_en_reg  <= (state_next == ST_PLAY);
            game_over_reg <= (state_next == ST_OVER);

            if ((state_reg == ST_ARM) && (arm_cnt_reg != '0))
                arm_cnt_reg <= arm_cnt_reg - ARM_W'(1);

            if (restart) begin
                arm_cnt_reg <= ARM_LOAD;
                score_reg   <= 16'd0;
                level_reg   <= 4'd1;
                hit_cnt_reg <= '0;
                pend_reg    <= 4'd0;
            end else begin
                // A miss and an accepted ack cancel each other out.
                if (over_entry)
                    pend_reg <= 4'd0;
                else if (miss_evt && !pend_ack) begin
                    if (pend_reg != PEND_TOP)
                        pend_reg <= pend_reg + 4'd1;
                end else if (!miss_evt && pend_ack)
                    pend_reg <= pend_reg - 4'd1;

                if (over_entry && (score_reg > best_reg))
                    best_reg <= score_reg;

                if (hit_evt) begin
                    score_reg <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
                    if (hit_cnt_reg == HIT_WRAP) begin
                        hit_cnt_reg <= '0;
                        if (level_reg != LEVEL_TOP)
                            level_reg <= level_reg + 4'd1;
                    end else begin
                        hit_cnt_reg <= hit_cnt_reg + HIT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench for game_flow_controller with a short arm phase.
module tb_game_flow_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        pause;
    logic        hit;
    logic        miss;
    logic        timer_expired;
    logic        penalty_ack;
    logic        timer_clr;
    logic        timer_en;
    logic        penalty_req;
    logic [2:0]  state;
    logic [15:0] score;
    logic [15:0] best_score;
    logic [3:0]  level;
    logic        game_over;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    game_flow_controller #(
        .ARM_CYCLES(4),
        .HIT_POINTS(10),
        .LEVEL_HITS(8),
        .MAX_LEVEL (9),
        .PEND_MAX  (15)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .pause        (pause),
        .hit          (hit),
        .miss         (miss),
        .timer_expired(timer_expired),
        .penalty_ack  (penalty_ack),
        .timer_clr    (timer_clr),
        .timer_en     (timer_en),
        .penalty_req  (penalty_req),
        .state        (state),
        .score        (score),
        .best_score   (best_score),
        .level        (level),
        .game_over    (game_over)
    );

    always #5 clock = ~clock;

    // Compare one observed value against its hand-computed expectation.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    // Advance one clock; inputs set before the call are sampled on the
    // rising edge, outputs are observed on the following falling edge.
    // One-cycle pulses are cleared afterwards.
    task automatic tick();
        @(negedge clock);
        pause = 0; hit = 0; miss = 0; timer_expired = 0; penalty_ack = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " state"}, 32'(state), 0);
        check({tag, " timer_clr"}, 32'(timer_clr), 1);
        check({tag, " timer_en"}, 32'(timer_en), 0);
        check({tag, " penalty_req"}, 32'(penalty_req), 0);
        check({tag, " score"}, 32'(score), 0);
        check({tag, " best_score"}, 32'(best_score), 0);
        check({tag, " level"}, 32'(level), 1);
        check({tag, " game_over"}, 32'(game_over), 0);
    endtask

    // Start edge followed by the four-cycle arm phase into PLAY.
    task automatic start_game();
        start = 0; tick();
        start = 1; tick();
        check("start->ARM state", 32'(state), 1);
        start = 0;
        for (int k = 2; k <= 4; k++) begin
            tick();
            check($sformatf("arm edge %0d state", k), 32'(state), 1);
        end
        tick();
        check("arm done state", 32'(state), 2);
    endtask

    initial begin
        reset = 1; start = 1; pause = 0; hit = 0; miss = 0;
        timer_expired = 0; penalty_ack = 0;
        @(negedge clock); @(negedge clock);
        check_reset_values("reset");

        // Start held high across reset release must not start a game.
        reset = 0;
        tick(); tick();
        check("held start state", 32'(state), 0);
        start = 0; tick();
        check("start low state", 32'(state), 0);

        // Toggle start, walk the arm phase; a hit during ARM is ignored.
        start = 1; tick();
        check("arm e1 state", 32'(state), 1);
        check("arm e1 timer_clr", 32'(timer_clr), 1);
        start = 0;
        hit = 1; tick();
        check("arm e2 state", 32'(state), 1);
        tick();
        check("arm e3 state", 32'(state), 1);
        tick();
        check("arm e4 state", 32'(state), 1);
        check("arm e4 timer_en", 32'(timer_en), 0);
        tick();
        check("play e5 state", 32'(state), 2);
        check("play e5 timer_en", 32'(timer_en), 1);
        check("play e5 timer_clr", 32'(timer_clr), 0);
        check("play e5 score", 32'(score), 0);

        // Nine hits: level steps on the eighth.
        for (int i = 1; i <= 9; i++) begin
            hit = 1; tick();
            if (i == 7) check("hit7 level", 32'(level), 1);
        end
        check("hit9 score", 32'(score), 90);
        check("hit9 level", 32'(level), 2);

        // Three misses with ack low build pend=3.
        check("pre-miss req", 32'(penalty_req), 0);
        miss = 1; tick();
        check("miss1 req", 32'(penalty_req), 1);
        miss = 1; tick();
        miss = 1; tick();
        penalty_ack = 1; tick();
        check("ack1 req", 32'(penalty_req), 1);
        pause = 1; tick();
        check("pause state", 32'(state), 3);
        check("pause req", 32'(penalty_req), 0);
        check("pause timer_en", 32'(timer_en), 0);
        for (int i = 0; i < 5; i++) begin
            penalty_ack = 1; hit = 1; miss = 1; tick();
        end
        check("paused ack req", 32'(penalty_req), 0);
        check("paused hit score", 32'(score), 90);
        pause = 1; tick();
        check("resume state", 32'(state), 2);
        check("resume req", 32'(penalty_req), 1);
        penalty_ack = 1; tick();
        check("drain pend1 req", 32'(penalty_req), 1);
        penalty_ack = 1; tick();
        check("drain pend0 req", 32'(penalty_req), 0);

        // Hit+miss together: miss wins. Then miss+ack with pend=1 holds pend.
        hit = 1; miss = 1; tick();
        check("hit+miss score", 32'(score), 90);
        check("hit+miss req", 32'(penalty_req), 1);
        miss = 1; penalty_ack = 1; tick();
        check("miss+ack req", 32'(penalty_req), 1);
        penalty_ack = 1; tick();
        check("after miss+ack drain req", 32'(penalty_req), 0);

        // Reach 120, leave a penalty pending, then expire with a dropped hit.
        for (int i = 0; i < 3; i++) begin
            hit = 1; tick();
        end
        check("score 120", 32'(score), 120);
        miss = 1; tick();
        timer_expired = 1; hit = 1; tick();
        check("over state", 32'(state), 4);
        check("over game_over", 32'(game_over), 1);
        check("over best", 32'(best_score), 120);
        check("over score", 32'(score), 120);
        check("over req", 32'(penalty_req), 0);
        check("over timer_en", 32'(timer_en), 0);

        // Second game ends at 50; best stays 120, pend was cleared.
        start_game();
        check("game2 score", 32'(score), 0);
        check("game2 best", 32'(best_score), 120);
        check("game2 level", 32'(level), 1);
        check("game2 req", 32'(penalty_req), 0);
        for (int i = 0; i < 5; i++) begin
            hit = 1; tick();
        end
        timer_expired = 1; tick();
        check("game2 over state", 32'(state), 4);
        check("game2 over score", 32'(score), 50);
        check("game2 over best", 32'(best_score), 120);

        // Level saturation over 88 hits.
        start_game();
        for (int i = 1; i <= 88; i++) begin
            hit = 1; tick();
            if (i == 63) check("hit63 level", 32'(level), 8);
            if (i == 80) check("hit80 level", 32'(level), 9);
        end
        check("hit88 level", 32'(level), 9);
        check("hit88 score", 32'(score), 880);

        // Asynchronous reset mid-cycle during PLAY with a pending penalty.
        miss = 1; tick();
        check("pre-reset req", 32'(penalty_req), 1);
        #2 reset = 1;
        #1 check_reset_values("async reset");
        @(negedge clock);
        reset = 0;
        tick();
        check("post-reset state", 32'(state), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
